// File: rtl/axis_slave_fifo_if.sv
// rtl/axis_slave_fifo_if.sv - upstream beat and downstream FWFT handshake signals for axis_slave_fifo
interface axis_slave_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  TVALID;
    logic [DATA_WIDTH-1:0] TDATA;
    logic                  TREADY;
    logic                  OUT_VALID;
    logic [DATA_WIDTH-1:0] OUT_DATA;
    logic                  OUT_READY;

    modport slave (
        input  TVALID,
        input  TDATA,
        output TREADY,
        output OUT_VALID,
        output OUT_DATA,
        input  OUT_READY
    );

    modport master (
        output TVALID,
        output TDATA,
        input  TREADY,
        input  OUT_VALID,
        input  OUT_DATA,
        output OUT_READY
    );
endinterface

// File: rtl/axis_slave_fifo.sv
// rtl/axis_slave_fifo.sv - stream slave buffer with first-word fall-through output
// TREADY depends on FILL only, and a pushed beat is never bypassed to the output in its own cycle.
module axis_slave_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     ACLK,
    input  logic                     ARST,
    axis_slave_fifo_if.slave         s,
    output logic [$clog2(DEPTH):0]   FILL,
    output logic [15:0]              BEAT_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW + 1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_fill;
    logic [15:0]           r_beat_cnt;

    logic w_tready;
    logic w_out_valid;
    logic w_push;
    logic w_pop;

    assign w_tready    = (r_fill < FULL_LVL);
    assign w_out_valid = (r_fill != '0);
    assign w_push      = s.TVALID & w_tready;
    assign w_pop       = w_out_valid & s.OUT_READY;

    assign s.TREADY    = w_tready;
    assign s.OUT_VALID = w_out_valid;
    assign s.OUT_DATA  = r_mem[r_rd_ptr];
    assign FILL        = r_fill;
    assign BEAT_CNT    = r_beat_cnt;

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s.TDATA;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fill     <= '0;
            r_beat_cnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_beat_cnt <= r_beat_cnt + 16'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + ONE;
                2'b01:   r_fill <= r_fill - ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end
endmodule
